// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - branch hazard/forwarding controller for ID-stage branch resolution
//
// Optional feature macro: BRANCH_STATS_EN (adds CNT_W, stall_cycles, taken_flushes)
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   hold                       external freeze; state and counters hold, pipeline frozen
//   id_branch, id_rs, id_rt    branch in ID and its source registers
//   branch_taken               ID comparator result on the forwarded operands
//   ex_reg_write/ex_mem_read/ex_wr_addr     ID/EX destination info
//   mem_reg_write/mem_mem_read/mem_wr_addr  EX/MEM destination info
//   fwd_rs_sel, fwd_rt_sel     00 regfile, 01 EX ALU result, 10 MEM write data
//   pc_write, ifid_write       PC / IF/ID update enables
//   idex_bubble                load a NOP into ID/EX
//   ifid_flush                 squash IF/ID on a taken branch
//   stall_cycles, taken_flushes  saturating statistics (BRANCH_STATS_EN only)
module branch_hazard_ctrl #(
   parameter int RAW = 5
`ifdef BRANCH_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           hold,
   input  logic           id_branch,
   input  logic [RAW-1:0] id_rs,
   input  logic [RAW-1:0] id_rt,
   input  logic           branch_taken,
   input  logic           ex_reg_write,
   input  logic           ex_mem_read,
   input  logic [RAW-1:0] ex_wr_addr,
   input  logic           mem_reg_write,
   input  logic           mem_mem_read,
   input  logic [RAW-1:0] mem_wr_addr,
   output logic [1:0]     fwd_rs_sel,
   output logic [1:0]     fwd_rt_sel,
   output logic           pc_write,
   output logic           ifid_write,
   output logic           idex_bubble,
   output logic           ifid_flush
`ifdef BRANCH_STATS_EN
   , output logic [CNT_W-1:0] stall_cycles
   , output logic [CNT_W-1:0] taken_flushes
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STALL2 = 2'd1;
   localparam logic [1:0] S_STALL1 = 2'd2;

   logic [1:0] state;
   logic [1:0] next_state;
   logic [1:0] need;
   logic [1:0] rs_dist;
   logic [1:0] rt_dist;
   logic       stall;

   // $0 is hardwired to zero, so it never matches a producer.
   function automatic logic reg_match(input logic [RAW-1:0] src, input logic [RAW-1:0] dst);
      return (src == dst) && (src != '0);
   endfunction

   // Stall cycles still needed for one operand; a load in EX outranks one in MEM.
   function automatic logic [1:0] hazard_dist(input logic [RAW-1:0] src);
      if (ex_mem_read && ex_reg_write && reg_match(src, ex_wr_addr))
         return 2'd2;
      else if (mem_mem_read && mem_reg_write && reg_match(src, mem_wr_addr))
         return 2'd1;
      else
         return 2'd0;
   endfunction

   // Only ALU results are forwardable; load data is not ready until WB.
   function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src);
      if (ex_reg_write && !ex_mem_read && reg_match(src, ex_wr_addr))
         return 2'b01;
      else if (mem_reg_write && !mem_mem_read && reg_match(src, mem_wr_addr))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      rs_dist = hazard_dist(id_rs);
      rt_dist = hazard_dist(id_rt);
      need    = (rs_dist > rt_dist) ? rs_dist : rt_dist;
      stall   = (state != S_IDLE) || (id_branch && (need != 2'd0));
   end

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE: begin
            if (id_branch && need == 2'd2)
               next_state = S_STALL2;
            else if (id_branch && need == 2'd1)
               next_state = S_STALL1;
            else
               next_state = S_IDLE;
         end
         S_STALL2: next_state = S_STALL1;
         S_STALL1: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      fwd_rs_sel  = 2'b00;
      fwd_rt_sel  = 2'b00;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
      if (rst_n) begin
         if (id_branch && state == S_IDLE && !stall) begin
            fwd_rs_sel = fwd_sel(id_rs);
            fwd_rt_sel = fwd_sel(id_rt);
         end
         if (hold) begin
            // Frozen pipeline: nothing advances and no bubble is injected.
            idex_bubble = 1'b0;
         end else if (stall) begin
            idex_bubble = 1'b1;
         end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_bubble = 1'b0;
            ifid_flush  = id_branch && branch_taken;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else if (!hold)
         state <= next_state;
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles  <= '0;
         taken_flushes <= '0;
      end else begin
         if (!hold && stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
         if (ifid_flush && taken_flushes != '1)
            taken_flushes <= taken_flushes + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hold;
   logic       id_branch;
   logic [4:0] id_rs, id_rt;
   logic       branch_taken;
   logic       ex_reg_write, ex_mem_read;
   logic [4:0] ex_wr_addr;
   logic       mem_reg_write, mem_mem_read;
   logic [4:0] mem_wr_addr;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic       pc_write, ifid_write, idex_bubble, ifid_flush;
`ifdef BRANCH_STATS_EN
   logic [15:0] stall_cycles, taken_flushes;
`endif

   int tests = 0;
   int fails = 0;

   branch_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_wr_addr(ex_wr_addr),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_wr_addr(mem_wr_addr),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush)
`ifdef BRANCH_STATS_EN
      , .stall_cycles(stall_cycles), .taken_flushes(taken_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: 'pending' is how many more stall cycles the controller has
   // committed to after a hazard was seen; zero means it is free to evaluate.
   int pending = 0;
   int m_stalls = 0;
   int m_flushes = 0;

   function automatic int m_dist(input logic [4:0] src);
      if (src != 0 && ex_reg_write && ex_mem_read && src == ex_wr_addr) return 2;
      if (src != 0 && mem_reg_write && mem_mem_read && src == mem_wr_addr) return 1;
      return 0;
   endfunction

   function automatic int m_need();
      int a = m_dist(id_rs);
      int b = m_dist(id_rt);
      return (a > b) ? a : b;
   endfunction

   function automatic bit m_stalling();
      return (pending > 0) || (id_branch && m_need() > 0);
   endfunction

   function automatic int m_fwd(input logic [4:0] src);
      if (!(id_branch && pending == 0 && m_need() == 0)) return 0;
      if (src != 0 && ex_reg_write && !ex_mem_read && src == ex_wr_addr) return 1;
      if (src != 0 && mem_reg_write && !mem_mem_read && src == mem_wr_addr) return 2;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   = 0;
         m_stalls  = 0;
         m_flushes = 0;
      end else if (!hold) begin
         if (m_stalling()) begin
            if (m_stalls < 65535) m_stalls++;
         end else if (id_branch && branch_taken) begin
            if (m_flushes < 65535) m_flushes++;
         end
         if (pending > 0) pending--;
         else if (id_branch) pending = m_need();
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int e_rs, e_rt, e_pc, e_bub, e_fl;
      if (!rst_n) begin
         e_rs = 0; e_rt = 0; e_pc = 0; e_bub = 1; e_fl = 0;
      end else begin
         e_rs = m_fwd(id_rs);
         e_rt = m_fwd(id_rt);
         if (hold) begin
            e_pc = 0; e_bub = 0; e_fl = 0;
         end else if (m_stalling()) begin
            e_pc = 0; e_bub = 1; e_fl = 0;
         end else begin
            e_pc = 1; e_bub = 0; e_fl = int'(id_branch && branch_taken);
         end
      end
      chk("m_fwd_rs", int'(fwd_rs_sel), e_rs);
      chk("m_fwd_rt", int'(fwd_rt_sel), e_rt);
      chk("m_pc_write", int'(pc_write), e_pc);
      chk("m_ifid_write", int'(ifid_write), e_pc);
      chk("m_idex_bubble", int'(idex_bubble), e_bub);
      chk("m_ifid_flush", int'(ifid_flush), e_fl);
`ifdef BRANCH_STATS_EN
      chk("m_stall_cycles", int'(stall_cycles), m_stalls);
      chk("m_taken_flushes", int'(taken_flushes), m_flushes);
`endif
   end

   task automatic clr();
      id_branch = 0; id_rs = 0; id_rt = 0; branch_taken = 0;
      ex_reg_write = 0; ex_mem_read = 0; ex_wr_addr = 0;
      mem_reg_write = 0; mem_mem_read = 0; mem_wr_addr = 0;
   endtask

   task automatic at_mid();
      @(negedge clk); #1;
   endtask

   task automatic next();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 0; hold = 0; clr();
      // Forward candidate present during reset must still give 00.
      id_branch = 1; id_rs = 5; ex_reg_write = 1; ex_wr_addr = 5;
      next(); at_mid();
      chk("rst_pc_write", pc_write, 0);
      chk("rst_bubble", idex_bubble, 1);
      chk("rst_flush", ifid_flush, 0);
      chk("rst_fwd_rs", fwd_rs_sel, 0);
      next(); rst_n = 1; clr();

      // ALU result in EX forwarded to rs, taken branch flushes.
      next(); id_branch = 1; id_rs = 5; id_rt = 6; branch_taken = 1; ex_reg_write = 1; ex_wr_addr = 5;
      at_mid();
      chk("alu_fwd_rs", fwd_rs_sel, 1);
      chk("alu_fwd_rt", fwd_rt_sel, 0);
      chk("alu_flush", ifid_flush, 1);
      chk("alu_pc_write", pc_write, 1);
      next(); clr(); at_mid();
      chk("alu_flush_one_cycle", ifid_flush, 0);

      // Load in EX on rt: IDLE stall, STALL2, STALL1, then resolve.
      next(); id_branch = 1; id_rs = 1; id_rt = 7; ex_reg_write = 1; ex_mem_read = 1; ex_wr_addr = 7;
      at_mid();
      chk("ldex_c0_bubble", idex_bubble, 1);
      chk("ldex_c0_pc", pc_write, 0);
      next(); ex_reg_write = 0; ex_mem_read = 0; ex_wr_addr = 0;
      mem_reg_write = 1; mem_mem_read = 1; mem_wr_addr = 7;
      at_mid(); chk("ldex_c1_bubble", idex_bubble, 1);
      next(); mem_reg_write = 0; mem_mem_read = 0; mem_wr_addr = 0;
      at_mid(); chk("ldex_c2_bubble", idex_bubble, 1);
      next(); at_mid();
      chk("ldex_c3_bubble", idex_bubble, 0);
      chk("ldex_c3_pc", pc_write, 1);
      chk("ldex_c3_fwd_rt", fwd_rt_sel, 0);

      // Load in MEM on rs: stall, STALL1, resolve.
      next(); clr(); id_branch = 1; id_rs = 3; mem_reg_write = 1; mem_mem_read = 1; mem_wr_addr = 3;
      at_mid(); chk("ldmem_c0_bubble", idex_bubble, 1);
      next(); mem_reg_write = 0; mem_mem_read = 0; mem_wr_addr = 0;
      at_mid(); chk("ldmem_c1_bubble", idex_bubble, 1);
      next(); at_mid(); chk("ldmem_c2_pc", pc_write, 1);

      // Mixed: load in EX on rs, ALU in MEM on rt -> the longer sequence.
      next(); clr(); id_branch = 1; id_rs = 4; id_rt = 9;
      ex_reg_write = 1; ex_mem_read = 1; ex_wr_addr = 4; mem_reg_write = 1; mem_wr_addr = 9;
      at_mid();
      chk("mix_c0_bubble", idex_bubble, 1);
      chk("mix_c0_fwd_rt", fwd_rt_sel, 0);
      next(); ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0;
      at_mid(); chk("mix_c1_bubble", idex_bubble, 1);
      next(); at_mid(); chk("mix_c2_bubble", idex_bubble, 1);
      next(); at_mid(); chk("mix_c3_pc", pc_write, 1);

      // $0 never stalls or forwards.
      next(); clr(); id_branch = 1; id_rs = 0; ex_reg_write = 1; ex_mem_read = 1; ex_wr_addr = 0;
      at_mid();
      chk("zero_pc", pc_write, 1);
      chk("zero_bubble", idex_bubble, 0);
      chk("zero_fwd_rs", fwd_rs_sel, 0);

      // Hold during STALL2 for three cycles.
      next(); clr(); id_branch = 1; id_rt = 7; ex_reg_write = 1; ex_mem_read = 1; ex_wr_addr = 7;
      at_mid(); chk("hold_c0_bubble", idex_bubble, 1);
      next(); clr(); id_branch = 1; hold = 1;
      for (int i = 0; i < 3; i++) begin
         at_mid();
         chk("hold_pc", pc_write, 0);
         chk("hold_bubble", idex_bubble, 0);
         next();
      end
      hold = 0;
      at_mid(); chk("hold_stall2_bubble", idex_bubble, 1);
      next(); at_mid(); chk("hold_stall1_bubble", idex_bubble, 1);
      next(); at_mid(); chk("hold_done_pc", pc_write, 1);

      // Asynchronous reset in STALL1.
      next(); clr(); id_branch = 1; id_rs = 3; mem_reg_write = 1; mem_mem_read = 1; mem_wr_addr = 3;
      next(); clr();
      #2 rst_n = 0; #1;
      chk("areset_pc", pc_write, 0);
      chk("areset_bubble", idex_bubble, 1);
      at_mid(); next(); rst_n = 1; at_mid();
      chk("areset_idle_pc", pc_write, 1);
      chk("areset_idle_bubble", idex_bubble, 0);

      // Randomised traffic on a small register set to provoke matches.
      for (int n = 0; n < 3000; n++) begin
         next();
         id_branch     = ($urandom_range(0, 3) != 0);
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         branch_taken  = 1'($urandom);
         ex_reg_write  = 1'($urandom);
         ex_mem_read   = ($urandom_range(0, 2) == 0);
         ex_wr_addr    = 5'($urandom_range(0, 3));
         mem_reg_write = 1'($urandom);
         mem_mem_read  = ($urandom_range(0, 2) == 0);
         mem_wr_addr   = 5'($urandom_range(0, 3));
         hold          = ($urandom_range(0, 9) == 0);
         rst_n         = ($urandom_range(0, 99) != 0);
         if (rst_n && $urandom_range(0, 49) == 0) begin
            #2 rst_n = 0;
            #1 rst_n = 1;
         end
      end

      next(); hold = 0; rst_n = 1; clr();
      at_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
